// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, delayed-branch redirects.
// Optional fetch-address checking is enabled by defining FETCH_ALIGN_CHK_EN.
//
// state | meaning
// BOOT  | first cycle after reset release, nothing captured
// RUN   | normal fetch, capture on every unstalled edge
// HALT  | fetch-address fault seen, frozen until reset
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          IM_DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc8,
  output logic [31:0] fetch_cnt,
  output logic        fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // 33-bit window bounds so RESET_PC near the top of the space cannot wrap
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << IM_DEPTH_LOG2);

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend_v;
  logic [31:0] next_pc;
  logic        addr_bad;
  logic        fault_det;
  logic        capture;
  logic        pc_load;
  logic        pend_set;
  logic        halt_hold;

  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect_valid)
      next_pc = redirect_pc;
    else if (pend_v)
      next_pc = pend_pc;
  end

  assign addr_bad  = (next_pc[1:0] != 2'b00) ||
                     ({1'b0, next_pc} < WIN_LO) ||
                     ({1'b0, next_pc} >= WIN_HI);
  assign fault_det = CHK_EN && addr_bad;

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= BOOT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!stall && fault_det) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    capture   = (state == RUN) && !stall;
    pc_load   = capture && !fault_det;
    pend_set  = (state == RUN) && stall && redirect_valid;
    halt_hold = (state == HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      pend_pc   <= 32'd0;
      pend_v    <= 1'b0;
      if_valid  <= 1'b0;
      if_instr  <= 32'd0;
      if_pc     <= 32'd0;
      fetch_cnt <= 32'd0;
      fault     <= 1'b0;
    end else begin
      if (capture) begin
        if_instr  <= im_instr;
        if_pc     <= pc;
        if_valid  <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
        pend_v    <= 1'b0;
      end
      if (pc_load)
        pc <= next_pc;
      // the faulting capture still lands; only the PC update is withheld
      if (capture && fault_det)
        fault <= 1'b1;
      if (pend_set) begin
        pend_pc <= redirect_pc;
        pend_v  <= 1'b1;
      end
      if (halt_hold)
        if_valid <= 1'b0;
    end
  end

  assign im_addr = pc;
  assign if_pc8  = if_pc + 32'd8;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized run
// against a fetch-stream reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic [31:0] fetch_cnt;
  logic        fault;

  logic [31:0] mem [1024];
  assign im_instr = mem[im_addr[11:2]];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc, m_pend_pc, m_instr, m_ifpc, m_cnt;
  logic        m_pend_v, m_valid, m_fault, m_boot, m_halt;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC), .IM_DEPTH_LOG2(10)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_instr(im_instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc8(if_pc8),
    .fetch_cnt(fetch_cnt), .fault(fault)
  );

  function automatic bit bad_addr(input logic [31:0] a);
    longint unsigned v = longint'(a);
    return (a[1:0] != 2'b00) || (v < longint'(RST_PC)) || (v >= longint'(RST_PC) + 4096);
  endfunction

  // one clock: drive at negedge, model the edge, return at the next negedge
  task automatic step(input logic rn, input logic st, input logic rv, input logic [31:0] rpc);
    logic [31:0] npc;
    reset_n = rn; stall = st; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    if (!rn) begin
      m_pc = RST_PC; m_pend_pc = 0; m_pend_v = 0; m_valid = 0; m_instr = 0;
      m_ifpc = 0; m_cnt = 0; m_fault = 0; m_boot = 1; m_halt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (st) begin
      if (rv) begin m_pend_v = 1; m_pend_pc = rpc; end
    end else begin
      npc = rv ? rpc : (m_pend_v ? m_pend_pc : m_pc + 32'd4);
      m_instr = mem[m_pc[11:2]]; m_ifpc = m_pc; m_valid = 1; m_cnt = m_cnt + 1; m_pend_v = 0;
      if (CHK && bad_addr(npc)) begin m_fault = 1; m_halt = 1; end
      else m_pc = npc;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0); step(0, 1, 1, 32'h5000);
    n_checks++; if (im_addr !== RST_PC) begin n_fail++; $display("FAIL rst_im_addr: got %h exp %h", im_addr, RST_PC); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b exp 0", if_valid); end
    n_checks++; if (if_instr !== 32'd0) begin n_fail++; $display("FAIL rst_if_instr: got %h exp 0", if_instr); end
    n_checks++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL rst_if_pc: got %h exp 0", if_pc); end
    n_checks++; if (if_pc8 !== 32'd8) begin n_fail++; $display("FAIL rst_if_pc8: got %h exp 8", if_pc8); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_fetch_cnt: got %0d exp 0", fetch_cnt); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b exp 0", fault); end
  endtask

  task automatic test_sequential;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_boot_valid: got %b exp 0", if_valid); end
    n_checks++; if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL seq_boot_addr: got %h exp 3000", im_addr); end
    step(1, 0, 0, 0);
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_instr !== 32'h11)
      begin n_fail++; $display("FAIL seq_cap0: got v=%b pc=%h i=%h exp v=1 pc=3000 i=11", if_valid, if_pc, if_instr); end
    n_checks++; if (if_pc8 !== 32'h3008) begin n_fail++; $display("FAIL seq_pc8: got %h exp 3008", if_pc8); end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3004 || if_instr !== 32'h22)
      begin n_fail++; $display("FAIL seq_cap1: got pc=%h i=%h exp pc=3004 i=22", if_pc, if_instr); end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3008 || if_instr !== 32'h33)
      begin n_fail++; $display("FAIL seq_cap2: got pc=%h i=%h exp pc=3008 i=33", if_pc, if_instr); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL seq_cnt: got %0d exp 3", fetch_cnt); end
  endtask

  task automatic test_stall;
    step(0, 0, 0, 0); run(3);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      n_checks++; if (if_pc !== 32'h3004 || im_addr !== 32'h3008 || if_valid !== 1'b1 || fetch_cnt !== 32'd2)
        begin n_fail++; $display("FAIL stall_hold%0d: got pc=%h addr=%h v=%b cnt=%0d exp pc=3004 addr=3008 v=1 cnt=2", i, if_pc, im_addr, if_valid, fetch_cnt); end
    end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3008 || if_instr !== 32'h33)
      begin n_fail++; $display("FAIL stall_resume: got pc=%h i=%h exp pc=3008 i=33", if_pc, if_instr); end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h300C || if_instr !== 32'h44)
      begin n_fail++; $display("FAIL stall_next: got pc=%h i=%h exp pc=300c i=44", if_pc, if_instr); end
  endtask

  task automatic test_delayed_branch;
    step(0, 0, 0, 0); run(4);
    n_checks++; if (im_addr !== 32'h300C) begin n_fail++; $display("FAIL br_pre: got %h exp 300c", im_addr); end
    step(1, 0, 1, 32'h3100);
    n_checks++; if (if_pc !== 32'h300C || im_addr !== 32'h3100)
      begin n_fail++; $display("FAIL br_slot: got pc=%h addr=%h exp pc=300c addr=3100", if_pc, im_addr); end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3100 || if_instr !== mem[64])
      begin n_fail++; $display("FAIL br_target: got pc=%h i=%h exp pc=3100 i=%h", if_pc, if_instr, mem[64]); end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3104) begin n_fail++; $display("FAIL br_after: got %h exp 3104", if_pc); end
  endtask

  task automatic test_redirect_stall;
    step(0, 0, 0, 0); run(3);
    step(1, 1, 1, 32'h3200);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    n_checks++; if (im_addr !== 32'h3008 || if_pc !== 32'h3004)
      begin n_fail++; $display("FAIL rs_hold: got addr=%h pc=%h exp addr=3008 pc=3004", im_addr, if_pc); end
    step(1, 0, 0, 0);
    n_checks++; if (im_addr !== 32'h3200 || if_pc !== 32'h3008)
      begin n_fail++; $display("FAIL rs_load: got addr=%h pc=%h exp addr=3200 pc=3008", im_addr, if_pc); end
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3200 || if_instr !== mem[128])
      begin n_fail++; $display("FAIL rs_cap: got pc=%h i=%h exp pc=3200 i=%h", if_pc, if_instr, mem[128]); end
  endtask

  task automatic test_mid_reset;
    step(0, 0, 0, 0); run(4);
    step(1, 1, 1, 32'h3300);
    step(0, 1, 1, 32'h3400);
    n_checks++; if (im_addr !== RST_PC || if_valid !== 1'b0 || if_pc !== 32'd0 || if_pc8 !== 32'd8 || fetch_cnt !== 32'd0 || fault !== 1'b0)
      begin n_fail++; $display("FAIL mr_vals: got addr=%h v=%b pc=%h pc8=%h cnt=%0d f=%b exp 3000/0/0/8/0/0", im_addr, if_valid, if_pc, if_pc8, fetch_cnt, fault); end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_checks++; if (if_pc !== 32'h3000 || im_addr !== 32'h3004)
      begin n_fail++; $display("FAIL mr_restart: got pc=%h addr=%h exp pc=3000 addr=3004", if_pc, im_addr); end
  endtask

  task automatic test_fault;
    step(0, 0, 0, 0); run(2);
    step(1, 0, 1, 32'h3002);
    if (CHK) begin
      n_checks++; if (fault !== 1'b1 || if_valid !== 1'b1 || if_pc !== 32'h3004 || im_addr !== 32'h3004)
        begin n_fail++; $display("FAIL flt_mis: got f=%b v=%b pc=%h addr=%h exp 1/1/3004/3004", fault, if_valid, if_pc, im_addr); end
      step(1, 0, 0, 0);
      n_checks++; if (if_valid !== 1'b0 || im_addr !== 32'h3004 || fetch_cnt !== 32'd2)
        begin n_fail++; $display("FAIL flt_halt: got v=%b addr=%h cnt=%0d exp 0/3004/2", if_valid, im_addr, fetch_cnt); end
    end else begin
      n_checks++; if (fault !== 1'b0 || im_addr !== 32'h3002)
        begin n_fail++; $display("FAIL flt_mis_off: got f=%b addr=%h exp 0/3002", fault, im_addr); end
      step(1, 0, 0, 0);
      n_checks++; if (if_pc !== 32'h3002 || if_instr !== mem[0])
        begin n_fail++; $display("FAIL flt_mis_cap: got pc=%h i=%h exp pc=3002 i=%h", if_pc, if_instr, mem[0]); end
    end
    step(0, 0, 0, 0); run(1);
    step(1, 0, 1, 32'h3FFC);
    step(1, 0, 0, 0);
    if (CHK) begin
      n_checks++; if (fault !== 1'b1 || im_addr !== 32'h3FFC || if_pc !== 32'h3FFC)
        begin n_fail++; $display("FAIL flt_end: got f=%b addr=%h pc=%h exp 1/3ffc/3ffc", fault, im_addr, if_pc); end
    end else begin
      n_checks++; if (fault !== 1'b0 || im_addr !== 32'h4000 || if_instr !== mem[1023])
        begin n_fail++; $display("FAIL flt_end_off: got f=%b addr=%h i=%h exp 0/4000/%h", fault, im_addr, if_instr, mem[1023]); end
    end
  endtask

  task automatic test_random;
    logic rn, st, rv;
    logic [31:0] rpc;
    step(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 99) < 15);
      rpc = RST_PC + (32'($urandom_range(0, 1023)) << 2);
      step(rn, st, rv, rpc);
      n_checks++; if (im_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h exp %h", i, im_addr, m_pc); end
      n_checks++; if (if_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b exp %b", i, if_valid, m_valid); end
      n_checks++; if (if_instr !== m_instr || if_pc !== m_ifpc || if_pc8 !== m_ifpc + 32'd8)
        begin n_fail++; $display("FAIL rnd_ifid@%0d: got i=%h pc=%h pc8=%h exp i=%h pc=%h pc8=%h", i, if_instr, if_pc, if_pc8, m_instr, m_ifpc, m_ifpc + 32'd8); end
      n_checks++; if (fetch_cnt !== m_cnt || fault !== m_fault)
        begin n_fail++; $display("FAIL rnd_cnt@%0d: got cnt=%0d f=%b exp cnt=%0d f=%b", i, fetch_cnt, fault, m_cnt, m_fault); end
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    @(negedge clk);
    test_reset;
    test_sequential;
    test_stall;
    test_delayed_branch;
    test_redirect_stall;
    test_mid_reset;
    test_fault;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the five-stage pipeline. It owns the PC and drives the read address of the combinational instruction memory (word index `pc[11:2]`, 1024 words). It captures the returned word into the IF/ID register. It sequences fetch under hazard-unit stalls and ID-stage branch/jump redirects, using MIPS delayed-branch semantics with no flush.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: first fetch address after reset.
- `IM_DEPTH_LOG2`, default `10`: log2 of the IM word count. Valid window is `[RESET_PC, RESET_PC + 4*2^IM_DEPTH_LOG2)`.

Ports:
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `stall`, input, 1: hazard-unit stall. While high, PC and IF/ID hold.
- `redirect_valid`, input, 1: a branch or jump resolved in ID as taken.
- `redirect_pc`, input, 32: target address for a redirect.
- `im_addr`, output, 32: equals the `pc` register (combinational).
- `im_instr`, input, 32: instruction word returned by IM in the same cycle.
- `if_valid`, output, 1: the IF/ID register holds a real instruction.
- `if_instr`, output, 32: IF/ID instruction.
- `if_pc`, output, 32: address of `if_instr`.
- `if_pc8`, output, 32: `if_pc + 8`, the link value for jal/jalr.
- `fetch_cnt`, output, 32: number of instructions captured.
- `fault`, output, 1: fetch-address fault (see Configuration).

## Operation
- **Next-PC priority**, when not stalled:
  1. `redirect_valid` selects `redirect_pc`.
  2. Otherwise a pending redirect selects `pend_pc`.
  3. Otherwise `pc + 4`. The add is 32-bit and wraps modulo 2^32.
- **Delayed branch.** The instruction fetched in the same cycle the redirect is seen (the delay slot) is captured normally. No instruction is ever squashed.
- **Redirect during stall.** If `redirect_valid` and `stall` are both high, latch `pend_pc <= redirect_pc` and set `pend_v <= 1`.
  - On the first cycle with `stall = 0`, the PC loads `pend_pc` and `pend_v` clears.
  - A newer redirect overwrites a pending one.
- **FSM states:**
  - `BOOT`: one cycle after reset release. `pc = RESET_PC`, nothing is captured, `if_valid = 0`. Always moves to `RUN`, even if `stall` is high.
  - `RUN`: normal fetch as below.
  - `HALT`: only reachable when `FETCH_ALIGN_CHK_EN` is defined.
- **Capture in `RUN` with `stall = 0`:**
  - `if_instr <= im_instr`, `if_pc <= pc`, `if_valid <= 1`.
  - `pc <= next_pc`, `fetch_cnt <= fetch_cnt + 1`, which wraps from `FFFF_FFFF` to 0.
- **`RUN` with `stall = 1`:** all registers hold, except the pending-redirect latch.

## Timing
- **Reset values** while `reset_n = 0` at a clock edge:
  - `pc` = `RESET_PC`, state = `BOOT`.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `if_pc8` = 8.
  - `fetch_cnt` = 0, `fault` = 0, `pend_v` = 0.
- **Reset mid-operation** overrides stall, redirect and `HALT` on that same edge.
- **Latency:**
  - `im_addr` to IF/ID capture is 1 cycle.
  - A redirect seen at edge N (no stall) makes `im_addr = redirect_pc` after edge N. That target is captured at edge N+1.
- **First instruction:** reset released before edge 0. Edge 0 leaves `BOOT`. Edge 1 captures the word at `RESET_PC` with `if_valid = 1`.
- **Stall:** `if_*` is held stable for every cycle `stall` is high. No capture is dropped or duplicated.

## Configuration
- **`FETCH_ALIGN_CHK_EN` defined:** in `RUN` with `stall = 0`, check `next_pc` before loading it.
  - A fault is `next_pc[1:0] != 0`, or `next_pc` outside the valid IM window.
  - On a fault: `fault <= 1`, go to `HALT`, and `pc` is not updated.
  - The current capture still completes on the faulting edge.
  - In `HALT`: `if_valid = 0` from the next edge on, `pc` and `fetch_cnt` freeze, and the state holds until reset.
- **`FETCH_ALIGN_CHK_EN` undefined:** no check. `fault` is tied to 0. Misaligned low PC bits pass straight through to `im_addr`; IM ignores them.

## Test plan
- **Reset and sequential fetch.** IM[0..3] = 11,22,33,44, no stall, release reset.
  - Expect `if_valid` 0 for the BOOT cycle.
  - Then `if_pc` = 3000, 3004, 3008 with `if_instr` = 11, 22, 33.
  - `if_pc8` = 3008 while `if_pc` = 3000. After 3 captures, `fetch_cnt` = 3.
- **Stall hold.** Assert `stall` for 3 cycles while `if_pc` = 3004.
  - `if_pc` stays 3004 and `im_addr` stays 3008.
  - After release, the next capture is 3008, with no skip and no duplicate.
- **Delayed branch.** Pulse `redirect_valid` with `redirect_pc` = 3100 while `pc` = 300C.
  - Captures are 300C (delay slot), then 3100, then 3104.
- **Redirect under stall.** With `stall` = 1, pulse redirect to 3200 for 1 cycle, then release stall 2 cycles later.
  - `pc` stays at its old value during the stall.
  - The first unstalled edge loads 3200. The capture after that has `if_pc` = 3200.
- **Mid-run reset.** Assert `reset_n` = 0 for 1 cycle during a stall with a pending redirect.
  - All outputs return to their reset values and `pend_v` = 0.
  - Fetch restarts at 3000.
- **Fault (macro defined).** Redirect to 3002: `fault` rises on that edge, `if_valid` drops next edge, `pc` holds. Separately, fetching past 3FFC also faults. With the macro undefined, the same redirect to 3002 gives `fault` = 0 and `im_addr` = 3002.
